// File: rtl/sd_reg_pkg.sv
// Shared definitions for the SD register access arbiter.
// Holds FSM state encoding, default sizes and port-id constants.
package sd_reg_pkg;

    localparam int NREG_DEF   = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int WIDTH_DEF  = 32;
    localparam int TMO_DEF    = 15;

    localparam logic HOST = 1'b0;
    localparam logic CORE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT_ACK,
        S_READ,
        S_RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter; bit 0 = host, bit 1 = core.
// Ports: clk, reset (async, active-low), req[1:0], advance, grant[1:0].
module rr_arb2
    import sd_reg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Port granted most recently; starts as CORE so the host wins
    // the first tie after reset.
    logic last;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == CORE) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= CORE;
        end else if (advance && (|grant)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates host and SD-core register accesses onto one register bank.
// Ports: clk, reset (async, active-low); host h_* and core c_* request
// ports (req/we/addr/wdata in, ack/err/rdata out); bank side
// reg_wr_valid/reg_wr_data out, reg_ack/reg_rd_data in; busy out.
module reg_access_arbiter
    import sd_reg_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int TMO    = TMO_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_W-1:0]     h_addr,
    input  logic [WIDTH-1:0]      h_wdata,
    output logic                  h_ack,
    output logic                  h_err,
    output logic [WIDTH-1:0]      h_rdata,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_W-1:0]     c_addr,
    input  logic [WIDTH-1:0]      c_wdata,
    output logic                  c_ack,
    output logic                  c_err,
    output logic [WIDTH-1:0]      c_rdata,
    output logic [NREG-1:0]       reg_wr_valid,
    output logic [WIDTH-1:0]      reg_wr_data,
    input  logic [NREG-1:0]       reg_ack,
    input  logic [NREG*WIDTH-1:0] reg_rd_data,
    output logic                  busy
);

    localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    state_t state, state_nx;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              advance;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [WIDTH-1:0]  g_wdata;
    logic              g_ok;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [WIDTH-1:0]  lat_wdata;
    logic              lat_port;
    logic              err_q;
    logic [CW-1:0]     cnt;
    logic              tmo_hit;

    logic              sel_ack;
    logic [WIDTH-1:0]  sel_rd;

    assign req     = {c_req, h_req};
    assign advance = (state == S_IDLE) && (|req);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign g_we    = grant[1] ? c_we    : h_we;
    assign g_addr  = grant[1] ? c_addr  : h_addr;
    assign g_wdata = grant[1] ? c_wdata : h_wdata;
    assign g_ok    = 32'(g_addr) < NREG;

    // Bank mux; addresses beyond NREG never match and read as 0/nack.
    always_comb begin
        sel_ack = 1'b0;
        sel_rd  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (lat_addr == ADDR_W'(i)) begin
                sel_ack = reg_ack[i];
                sel_rd  = reg_rd_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign tmo_hit = (cnt == CW'(TMO - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (advance) begin
                    if (!g_ok) begin
                        state_nx = S_RESP;
                    end else if (g_we) begin
                        state_nx = S_WRITE;
                    end else begin
                        state_nx = S_READ;
                    end
                end
            end
            S_WRITE:    state_nx = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (sel_ack || tmo_hit) begin
                    state_nx = S_RESP;
                end
            end
            S_READ:     state_nx = S_RESP;
            S_RESP:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_port  <= HOST;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (advance) begin
                        lat_we    <= g_we;
                        lat_addr  <= g_addr;
                        lat_wdata <= g_wdata;
                        lat_port  <= grant[1];
                        err_q     <= !g_ok;
                    end
                end
                S_WRITE: cnt <= '0;
                S_WAIT_ACK: begin
                    cnt <= cnt + CW'(1);
                    if (!sel_ack && tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                S_READ: err_q <= !sel_ack;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_rdata <= '0;
            c_rdata <= '0;
        end else if (state == S_READ) begin
            if (lat_port == HOST) begin
                h_rdata <= sel_rd;
            end else begin
                c_rdata <= sel_rd;
            end
        end
    end

    always_comb begin
        reg_wr_valid = '0;
        for (int i = 0; i < NREG; i++) begin
            if (state == S_WRITE && lat_addr == ADDR_W'(i)) begin
                reg_wr_valid[i] = 1'b1;
            end
        end
    end

    assign reg_wr_data = (state == S_WRITE) ? lat_wdata : '0;

    assign h_ack = (state == S_RESP) && (lat_port == HOST);
    assign c_ack = (state == S_RESP) && (lat_port == CORE);
    assign h_err = h_ack && err_q;
    assign c_err = c_ack && err_q;
    assign busy  = (state != S_IDLE);

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameters SHALL be: NREG, default 16, number of registers; ADDR_W, default 4, register index width; WIDTH, default 32, data width; TMO, default 15, max wait cycles for register acknowledge.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 h_req / h_we / h_addr / h_wdata  in  1/1/ADDR_W/WIDTH  host request, write-enable, register index, write data.
REQ-005 h_ack / h_err / h_rdata  out  1/1/WIDTH  host completion pulse, timeout flag, read data.
REQ-006 c_req / c_we / c_addr / c_wdata  in  1/1/ADDR_W/WIDTH  SD-core request port, same meaning as host port.
REQ-007 c_ack / c_err / c_rdata  out  1/1/WIDTH  SD-core completion pulse, timeout flag, read data.
REQ-008 reg_wr_valid  out  NREG  one-hot write strobe into the register bank.
REQ-009 reg_wr_data  out  WIDTH  write data into the register bank.
REQ-010 reg_ack  in  NREG  per-register acknowledge (1 = data reliable).
REQ-011 reg_rd_data  in  NREG*WIDTH  flattened register outputs; register i at bits [i*WIDTH +: WIDTH].
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WRITE, WAIT_ACK, READ, RESP.
REQ-014 In IDLE with at least one request, the block SHALL grant one port, latch its we/addr/wdata and port id, and go to WRITE (we=1) or READ (we=0) next cycle.
REQ-015 Arbitration SHALL be round-robin: simultaneous requests go to the port not granted last; after reset the host port SHALL win the first tie.
REQ-016 A single requester SHALL be granted regardless of round-robin pointer; the pointer SHALL update only on grant.
REQ-017 WRITE SHALL last exactly one cycle with reg_wr_valid[addr]=1, all other bits 0, reg_wr_data=latched wdata; then go to WAIT_ACK.
REQ-018 WAIT_ACK SHALL hold reg_wr_valid=0 and go to RESP on the first cycle reg_ack[addr]=1.
REQ-019 If reg_ack[addr] stays 0 for TMO consecutive WAIT_ACK cycles, the block SHALL go to RESP with the error flag set.
REQ-020 READ SHALL last one cycle, capturing reg_rd_data slice [addr] into the granted port's rdata register; if reg_ack[addr]=0 in that cycle, the error flag SHALL be set.
REQ-021 RESP SHALL last one cycle: the granted port's ack=1 and err=error flag; the other port's ack and err SHALL be 0; then IDLE.
REQ-022 Requesters hold req and operands until ack; requests SHALL be sampled only in IDLE; operand changes during a transaction SHALL be ignored.
REQ-023 Write latency SHALL be 3 cycles from grant to ack when reg_ack is already 1; read latency SHALL be 2 cycles from grant to ack.
REQ-024 h_rdata/c_rdata SHALL hold their last captured value until the next read on that port.
REQ-025 addr >= NREG SHALL skip the bank access, go directly to RESP with err=1, and assert no reg_wr_valid bit.
REQ-026 A request deasserted in IDLE before grant SHALL be dropped with no ack.

Reset
REQ-027 On reset=0: state=IDLE, round-robin pointer=host-first, error flag=0, latched fields=0.
REQ-028 On reset=0: all outputs (acks, errs, rdata, reg_wr_valid, reg_wr_data, busy) SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no ack, and the next transaction SHALL start from IDLE.

Structure
REQ-030 The state encoding, NREG/ADDR_W/WIDTH/TMO defaults and port-id constants (HOST=0, CORE=1) SHALL live in shared package sd_reg_pkg.
REQ-031 The two-port round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], advance; output grant[1:0]); everything else SHALL stay in one module.

Verification
REQ-032 Host write addr 3, data 32'hDEAD_BEEF, reg_ack all 1 -> reg_wr_valid=16'h0008 for one cycle; h_ack=1, h_err=0 three cycles after grant.
REQ-033 h_req and c_req both high from reset, both reads -> host acked first, core acked next; a third tie -> host granted (alternation).
REQ-034 Core write addr 5 with reg_ack[5] held 0 -> c_ack=1, c_err=1 after exactly 15 WAIT_ACK cycles.
REQ-035 Core read addr 2, reg_rd_data slice 2 = 32'h0000_1234, reg_ack[2]=1 -> c_rdata=32'h0000_1234, c_ack one cycle after READ.
REQ-036 reset driven low during WAIT_ACK -> all outputs 0 immediately; no ack; next host write completes normally.
REQ-037 Host write with NREG=12, addr 4'hF -> no reg_wr_valid bit set; h_ack=1, h_err=1 one cycle after grant.
